// File: rtl/if_pkg.sv
// Shared types for the prefetching instruction-fetch stage: fetch FSM states,
// default instruction size and the default prefetch queue entry layout.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int unsigned ADDR_W_DEFAULT      = 32;
    localparam int unsigned INSTR_W_DEFAULT     = 32;
    localparam int unsigned INSTR_BYTES_DEFAULT = 4;

    // pc holds the fetch address plus one instruction, as seen by ID.
    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0]  pc;
        logic [INSTR_W_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory request/response bus: one-cycle request pulse,
// one-cycle in-order response strobe, a single request outstanding.
interface if_prefetch_stage_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fifo.sv
// Synchronous prefetch queue with flush, occupancy count and a combinational
// head view that reads as zero while empty.
module if_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             push_en;
    logic             pop_en;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_en = push_i && !full;
    assign pop_en  = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    // NOTE: the storage array is deliberately not reset; the count masks stale
    // contents, so only the pointers and count need a reset.
    always_ff @(posedge clk) begin
        if (push_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with a DEPTH-entry prefetch queue between a variable-latency
// instruction memory and ID; branches flush the queue and drain in-flight fetches.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INSTR_W     = 32,
    parameter int unsigned       DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         branchTaken,
    input  logic [ADDR_W-1:0]            branchAddress,
    if_prefetch_stage_if.master          imem,
    output logic                         valid,
    output logic [ADDR_W-1:0]            pc,
    output logic [INSTR_W-1:0]           instruction,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned       CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;

    logic              push;
    logic              pop;
    logic              flush;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  occ_after_pop;
    entry_t            head;
    entry_t            push_entry;

    assign valid         = !empty;
    assign pop           = valid && !freeze;
    assign occ_after_pop = count - CNT_W'(pop);

    // While a request is outstanding fetch_pc_q already points one past it,
    // which is exactly the pc ID expects for that instruction.
    assign push_entry = '{pc: fetch_pc_q, instr: imem.imem_rdata};

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;

        if (branchTaken) begin
            flush      = 1'b1;
            fetch_pc_d = branchAddress & ALIGN_MASK;
            case (state_q)
                WAIT:    state_d = imem.imem_rvalid ? IDLE : DRAIN;
                DRAIN:   state_d = imem.imem_rvalid ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    // Reserve a slot now so the eventual push cannot overflow.
                    if (occ_after_pop < DEPTH_C) begin
                        req_d      = 1'b1;
                        addr_d     = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + STEP;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        push = 1'b1;
                        if (occ_after_pop < DEPTH_C - CNT_W'(1)) begin
                            req_d      = 1'b1;
                            addr_d     = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + STEP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (imem.imem_rvalid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    if_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .count_o (count)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc             = head.pc;
    assign instruction    = head.instr;
    assign fifo_count     = count;

endmodule
